arcade_input_mapper: RTL and testbench

Parametrised player-control front end for arcade cores: converts up to `NUM_PLAYERS` 16-bit HPS joystick words into per-player direction/button lines, start lines and a shaped coin pulse. Adds a shared/separate controller mode, per-button autofire and a queued coin pulse generator that guarantees the CPU-visible coin width and gap. Sits between `hps_io` and the game core in `emu`, in the `clk_sys` domain.

---
 rtl/arcade_input_pkg.sv | 25 ++
 rtl/arcade_input_mapper_coin_shaper.sv | 109 ++++++++++
 rtl/arcade_input_mapper.sv | 132 +++++++++++++
 tb/tb_arcade_input_mapper.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared constants, bit-index helpers and coin FSM state type
//
// Purpose: joystick word layout and coin shaper state encoding.
// Word layout: [3:0] {up,down,left,right}, then NB buttons, NP starts, coin.

package arcade_input_pkg;

    localparam int JOY_W    = 16;
    localparam int BIT_BTN0 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    function automatic int bit_start(input int k, input int nb);
        return BIT_BTN0 + nb + k;
    endfunction

    function automatic int bit_coin(input int nb, input int np);
        return BIT_BTN0 + nb + np;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_shaper.sv
// rtl/arcade_input_mapper_coin_shaper.sv - coin edge detect, pending queue and pulse/gap shaper
//
// Purpose: turns rising edges of the registered coin line into fixed-width
// coin pulses separated by a minimum gap, queueing up to three coins.
// Ports:
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   coin_raw     in   registered (merged) coin line
//   coin         out  shaped coin pulse, high only in PULSE
//   coin_pending out  queued coins not yet emitted (0..3)

module coin_shaper
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE = 1200000,
    parameter int COIN_GAP   = 600000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       coin_raw,
    output logic       coin,
    output logic [1:0] coin_pending
);

    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP - 1);

    coin_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             coin_d;
    logic             armed;
    logic             rise;
    logic             take;
    logic             dec;
    logic [2:0]       pend_sum;
    logic [1:0]       pend_nxt;

    // coin_d resets high so the reset value of the input register cannot
    // arm the detector: two genuinely observed low cycles are needed, which
    // ignores a coin held through reset.
    assign rise = coin_raw & ~coin_d & armed;

    // An edge arriving while idle (or at the end of a gap) launches a pulse
    // straight away, so the pending count never visibly shows it.
    assign take = (coin_pending != 2'd0) || rise;
    assign dec  = take && ((state == IDLE) || ((state == GAP) && (cnt == GAP_LAST)));

    // Saturate after the net change so a simultaneous edge+launch at 3 holds 3.
    always_comb begin
        pend_sum = {1'b0, coin_pending} + {2'b00, rise} - {2'b00, dec};
        pend_nxt = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_d       <= 1'b1;
            armed        <= 1'b0;
            coin_pending <= 2'd0;
            state        <= IDLE;
            cnt          <= '0;
            coin         <= 1'b0;
        end else begin
            coin_d       <= coin_raw;
            if (!coin_raw && !coin_d) begin
                armed <= 1'b1;
            end
            coin_pending <= pend_nxt;
            case (state)
                IDLE: begin
                    if (take) begin
                        state <= PULSE;
                        cnt   <= '0;
                        coin  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        coin  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (take) begin
                            state <= PULSE;
                            coin  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - joystick words to per-player controls, starts and shaped coin
//
// Purpose: registers the HPS joystick words, maps them to per-player
// direction/button lines (shared or separate), applies per-button
// autofire and shapes the coin line through coin_shaper.
// Ports:
//   clk_sys       in   system clock
//   reset_n       in   asynchronous active-low reset
//   joy_in        in   NUM_PLAYERS joystick words, player p at [16p+15:16p]
//   share_mode    in   1: all players from OR of all words
//   autofire_mask in   per-button autofire enable
//   p_dir         out  {up,down,left,right} per player
//   p_btn         out  buttons per player
//   start         out  start lines (from merged word)
//   coin          out  shaped coin pulse
//   coin_pending  out  queued coins not yet emitted

module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 2,
    parameter int COIN_PULSE   = 1200000,
    parameter int COIN_GAP     = 600000,
    parameter int AUTOFIRE_DIV = 600000
) (
    input  logic                               clk_sys,
    input  logic                               reset_n,
    input  logic [JOY_W*NUM_PLAYERS-1:0]       joy_in,
    input  logic                               share_mode,
    input  logic [NUM_BUTTONS-1:0]             autofire_mask,
    output logic [4*NUM_PLAYERS-1:0]           p_dir,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_btn,
    output logic [NUM_PLAYERS-1:0]             start,
    output logic                               coin,
    output logic [1:0]                         coin_pending
);

    localparam int START0   = bit_start(0, NUM_BUTTONS);
    localparam int COIN_BIT = bit_coin(NUM_BUTTONS, NUM_PLAYERS);
    localparam int AF_W     = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_DIV - 1);

    logic [JOY_W*NUM_PLAYERS-1:0] joy_r;
    logic                         share_r;
    logic [NUM_BUTTONS-1:0]       mask_r;
    logic [JOY_W-1:0]             merged;
    logic                         unused_merged;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_r   <= '0;
            share_r <= 1'b0;
            mask_r  <= '0;
        end else begin
            joy_r   <= joy_in;
            share_r <= share_mode;
            mask_r  <= autofire_mask;
        end
    end

    always_comb begin
        merged = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            merged = merged | joy_r[JOY_W*p +: JOY_W];
        end
    end

    // Bits above the coin position carry nothing for this mapping.
    assign unused_merged = ^merged;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            start <= '0;
        end else begin
            start <= merged[START0 +: NUM_PLAYERS];
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]             dir_src;
        logic [NUM_BUTTONS-1:0] pressed;
        logic                   held;
        logic [AF_W-1:0]        af_cnt;
        logic                   af_phase;
        logic [3:0]             dir_q;
        logic [NUM_BUTTONS-1:0] btn_q;

        assign dir_src = share_r ? merged[3:0] : joy_r[JOY_W*p +: 4];
        assign pressed = share_r ? merged[BIT_BTN0 +: NUM_BUTTONS]
                                 : joy_r[JOY_W*p + BIT_BTN0 +: NUM_BUTTONS];
        assign held    = |(pressed & mask_r);

        // Phase starts at 1 whenever nothing masked is held, so the first
        // shot of every autofire burst is immediate.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
                dir_q    <= '0;
                btn_q    <= '0;
            end else begin
                dir_q <= dir_src;
                btn_q <= pressed & (~mask_r | {NUM_BUTTONS{af_phase}});
                if (!held) begin
                    af_cnt   <= '0;
                    af_phase <= 1'b1;
                end else if (af_cnt == AF_LAST) begin
                    af_cnt   <= '0;
                    af_phase <= ~af_phase;
                end else begin
                    af_cnt <= af_cnt + AF_W'(1);
                end
            end
        end

        assign p_dir[4*p +: 4]                     = dir_q;
        assign p_btn[NUM_BUTTONS*p +: NUM_BUTTONS] = btn_q;
    end

    coin_shaper #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin_shaper (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .coin_raw     (merged[COIN_BIT]),
        .coin         (coin),
        .coin_pending (coin_pending)
    );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - self-checking bench for arcade_input_mapper

module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] joy_in;
    logic        share_mode;
    logic [1:0]  autofire_mask;
    logic [7:0]  p_dir;
    logic [3:0]  p_btn;
    logic [1:0]  start;
    logic        coin;
    logic [1:0]  coin_pending;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];
    logic        coin_q[$];

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS  (2),
        .NUM_BUTTONS  (2),
        .COIN_PULSE   (8),
        .COIN_GAP     (4),
        .AUTOFIRE_DIV (3)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .joy_in        (joy_in),
        .share_mode    (share_mode),
        .autofire_mask (autofire_mask),
        .p_dir         (p_dir),
        .p_btn         (p_btn),
        .start         (start),
        .coin          (coin),
        .coin_pending  (coin_pending)
    );

    // Expected {p_dir, p_btn, start} for one input word pair, no autofire.
    function automatic logic [13:0] map_exp(input logic [31:0] j, input logic s);
        logic [15:0] m;
        logic [15:0] w;
        logic [7:0]  d;
        logic [3:0]  b;
        m = j[15:0] | j[31:16];
        d = '0;
        b = '0;
        for (int p = 0; p < 2; p++) begin
            w = s ? m : j[16*p +: 16];
            d[4*p +: 4] = w[3:0];
            b[2*p +: 2] = w[5:4];
        end
        return {d, b, m[7:6]};
    endfunction

    task automatic drive(input logic [31:0] j, input logic s, input logic [1:0] m);
        @(negedge clk_sys);
        joy_in        = j;
        share_mode    = s;
        autofire_mask = m;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        joy_in        = 32'hFFFF_FFFF;
        share_mode    = 1'b1;
        autofire_mask = 2'b11;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({p_dir, p_btn, start} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", {p_dir, p_btn, start});
        end
        checks++;
        if (coin !== 1'b0) begin
            errors++;
            $display("FAIL reset_coin: got %b expected 0", coin);
        end
        checks++;
        if (coin_pending !== 2'd0) begin
            errors++;
            $display("FAIL reset_pending: got %0d expected 0", coin_pending);
        end
        joy_in        = '0;
        share_mode    = 1'b0;
        autofire_mask = 2'b00;
        reset_n       = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({p_dir, p_btn, start, coin} !== 15'd0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", {p_dir, p_btn, start, coin});
        end
    endtask

    task automatic test_map();
        logic [31:0] j;
        logic        s;
        logic [13:0] e;
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: begin j = 32'h0009_0000; s = 1'b0; e = {8'b1001_0000, 4'b0000, 2'b00}; end
                1: begin j = 32'h0009_0000; s = 1'b1; e = {8'b1001_1001, 4'b0000, 2'b00}; end
                2: begin j = 32'h0000_0080; s = 1'b0; e = {8'h00, 4'b0000, 2'b10}; end
                3: begin j = 32'h0040_0000; s = 1'b0; e = {8'h00, 4'b0000, 2'b01}; end
                default: begin
                    j = $urandom & 32'h00FF_00FF;
                    s = 1'($urandom_range(0, 1));
                    e = map_exp(j, s);
                end
            endcase
            drive(j, s, 2'b00);
            exp_q.push_back(e);
            if (exp_q.size() > 1) begin
                e = exp_q.pop_front();
                checks++;
                if ({p_dir, p_btn, start} !== e) begin
                    errors++;
                    $display("FAIL map[%0d]: got %h expected %h", k - 1, {p_dir, p_btn, start}, e);
                end
            end
        end
        drive(j, s, 2'b00);
        e = exp_q.pop_front();
        checks++;
        if ({p_dir, p_btn, start} !== e) begin
            errors++;
            $display("FAIL map_last: got %h expected %h", {p_dir, p_btn, start}, e);
        end
    endtask

    // Button bit 4 autofired (3 on, 3 off), bit 5 held solid; a release
    // restarts the burst with an immediate shot.
    task automatic test_autofire();
        logic [31:0] j;
        logic [13:0] e;
        int          i;
        for (int k = 0; k < 27; k++) begin
            i = 0;
            if (k < 20) begin
                j = 32'h0000_0030;
                i = k;
            end else if (k == 20 || k == 26) begin
                j = 32'h0;
            end else begin
                j = 32'h0000_0030;
                i = k - 21;
            end
            e = (j == 32'h0) ? 14'd0 : {8'h00, 2'b00, 1'b1, ((i / 3) % 2 == 0), 2'b00};
            drive(j, 1'b0, 2'b01);
            exp_q.push_back(e);
            if (exp_q.size() > 1) begin
                e = exp_q.pop_front();
                checks++;
                if ({p_dir, p_btn, start} !== e) begin
                    errors++;
                    $display("FAIL autofire[%0d]: got %h expected %h", k - 1, {p_dir, p_btn, start}, e);
                end
            end
        end
        drive(32'h0, 1'b0, 2'b01);
        e = exp_q.pop_front();
        checks++;
        if ({p_dir, p_btn, start} !== e) begin
            errors++;
            $display("FAIL autofire_last: got %h expected %h", {p_dir, p_btn, start}, e);
        end
    endtask

    task automatic test_coin_single();
        logic c;
        coin_q.push_back(1'b0);
        repeat (8) coin_q.push_back(1'b1);
        repeat (6) coin_q.push_back(1'b0);
        for (int k = 0; k < 15; k++) begin
            drive((k == 0) ? 32'h0000_0100 : 32'h0, 1'b0, 2'b00);
            c = coin_q.pop_front();
            checks++;
            if (coin !== c) begin
                errors++;
                $display("FAIL coin_single[%0d]: got %b expected %b", k, coin, c);
            end
            checks++;
            if (coin_pending !== 2'd0) begin
                errors++;
                $display("FAIL pending_single[%0d]: got %0d expected 0", k, coin_pending);
            end
        end
    endtask

    // Five taps two cycles apart: one launches at once, three queue, the
    // fifth is dropped at saturation.
    task automatic test_coin_burst();
        logic       c;
        logic [1:0] ep;
        coin_q.push_back(1'b0);
        for (int n = 0; n < 4; n++) begin
            repeat (8) coin_q.push_back(1'b1);
            if (n < 3) repeat (4) coin_q.push_back(1'b0);
        end
        repeat (6) coin_q.push_back(1'b0);
        for (int k = 0; k < 51; k++) begin
            drive((k <= 8 && k % 2 == 0) ? 32'h0000_0100 : 32'h0, 1'b0, 2'b00);
            c = coin_q.pop_front();
            checks++;
            if (coin !== c) begin
                errors++;
                $display("FAIL coin_burst[%0d]: got %b expected %b", k, coin, c);
            end
            if (k == 7 || k == 12 || k == 13 || k == 50) begin
                ep = (k == 13) ? 2'd2 : ((k == 50) ? 2'd0 : 2'd3);
                checks++;
                if (coin_pending !== ep) begin
                    errors++;
                    $display("FAIL pending_burst[%0d]: got %0d expected %0d", k, coin_pending, ep);
                end
            end
        end
    endtask

    task automatic test_coin_reset();
        logic c;
        @(negedge clk_sys);
        joy_in  = 32'h0000_0100;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            drive((k < 12) ? 32'h0000_0100 : 32'h0, 1'b0, 2'b00);
            checks++;
            if (coin !== 1'b0 || coin_pending !== 2'd0) begin
                errors++;
                $display("FAIL coin_held_reset[%0d]: got %b/%0d expected 0/0", k, coin, coin_pending);
            end
        end
        coin_q.push_back(1'b0);
        repeat (3) coin_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) begin
            drive((k == 0) ? 32'h0000_0100 : 32'h0, 1'b0, 2'b00);
            c = coin_q.pop_front();
            checks++;
            if (coin !== c) begin
                errors++;
                $display("FAIL coin_repress[%0d]: got %b expected %b", k, coin, c);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (coin !== 1'b0) begin
            errors++;
            $display("FAIL coin_async_reset: got %b expected 0", coin);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (12) begin
            drive(32'h0, 1'b0, 2'b00);
            checks++;
            if (coin !== 1'b0) begin
                errors++;
                $display("FAIL coin_after_reset: got %b expected 0", coin);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_map();
        test_autofire();
        test_coin_single();
        test_coin_burst();
        test_coin_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
